// File: rtl/custom_axi_ip_pkg.sv
// Shared types for the custom IP and its register-side host interface.
// status_e mirrors the IP's status port; host_state_e is the initiator FSM.
package custom_axi_ip_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        H_IDLE  = 2'd0,
        H_ISSUE = 2'd1,
        H_WAIT  = 2'd2,
        H_RSP   = 2'd3
    } host_state_e;

    localparam int unsigned HOST_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/ipreg_host_timeout.sv
// Saturating watchdog counter with synchronous clear, count enable and a
// terminal flag that rises once LIMIT-1 cycles have been counted.
module ipreg_host_timeout #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(LIMIT);
    localparam logic [CW-1:0] CNT_TERM = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Holding at LIMIT keeps the terminal flag asserted without ever wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign terminal_o = (cnt_q >= CNT_TERM);

endmodule

// File: rtl/ipreg_host_if.sv
// Register-side initiator: issues one command to the IP, tracks its status
// sequence, and returns the result. Optional stats via IPREG_HOST_STATS_EN.
module ipreg_host_if
    import custom_axi_ip_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = HOST_TIMEOUT_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [DATA_WIDTH-1:0] cmd_data_i,
    output logic [DATA_WIDTH-1:0] ip_data_o,
    output logic                  ip_enable_o,
    input  logic [DATA_WIDTH-1:0] ip_data_i,
    input  status_e               ip_status_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_error_o,
    output logic                  rsp_timeout_o,
`ifdef IPREG_HOST_STATS_EN
    output logic [15:0]           stat_ok_o,
    output logic [15:0]           stat_err_o,
    input  logic                  stat_clr_i,
`endif
    output logic                  busy_o
);

    host_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] ip_data_q, ip_data_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_error_q, rsp_error_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  seen_done_q, seen_done_d;
    logic                  cnt_clear, cnt_en, cnt_term;

    ipreg_host_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (cnt_clear),
        .enable_i   (cnt_en),
        .terminal_o (cnt_term)
    );

    // The IP must be idle before a new command may be started.
    assign cmd_ready_o   = (state_q == H_IDLE) && (ip_status_i == IDLE);
    assign ip_enable_o   = (state_q == H_ISSUE);
    assign rsp_valid_o   = (state_q == H_RSP);
    assign busy_o        = (state_q != H_IDLE);
    assign ip_data_o     = ip_data_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_error_o   = rsp_error_q;
    assign rsp_timeout_o = rsp_timeout_q;

    always_comb begin
        state_d       = state_q;
        ip_data_d     = ip_data_q;
        rsp_data_d    = rsp_data_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;
        seen_done_d   = seen_done_q;
        cnt_clear     = 1'b0;
        cnt_en        = 1'b0;
        case (state_q)
            H_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    ip_data_d = cmd_data_i;
                    state_d   = H_ISSUE;
                end
            end
            H_ISSUE: begin
                cnt_clear   = 1'b1;
                seen_done_d = 1'b0;
                state_d     = H_WAIT;
            end
            H_WAIT: begin
                cnt_en = 1'b1;
                if (ip_status_i == DONE) begin
                    seen_done_d = 1'b1;
                end
                // ERROR beats a completion, which beats the watchdog.
                if (ip_status_i == ERROR) begin
                    rsp_data_d    = ip_data_i;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                    state_d       = H_RSP;
                end else if ((ip_status_i == IDLE) && seen_done_q) begin
                    rsp_data_d    = ip_data_i;
                    rsp_error_d   = 1'b0;
                    rsp_timeout_d = 1'b0;
                    state_d       = H_RSP;
                end else if (cnt_term) begin
                    rsp_data_d    = '0;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = H_RSP;
                end
            end
            H_RSP: begin
                if (rsp_ready_i) begin
                    state_d = H_IDLE;
                end
            end
            default: state_d = H_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= H_IDLE;
            ip_data_q     <= '0;
            rsp_data_q    <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            seen_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ip_data_q     <= ip_data_d;
            rsp_data_q    <= rsp_data_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
            seen_done_q   <= seen_done_d;
        end
    end

`ifdef IPREG_HOST_STATS_EN
    logic [15:0] stat_ok_q, stat_ok_d;
    logic [15:0] stat_err_q, stat_err_d;
    logic        rsp_hsk;

    assign rsp_hsk    = rsp_valid_o && rsp_ready_i;
    assign stat_ok_o  = stat_ok_q;
    assign stat_err_o = stat_err_q;

    // Clear takes precedence over a coincident response handshake.
    always_comb begin
        stat_ok_d  = stat_ok_q;
        stat_err_d = stat_err_q;
        if (stat_clr_i) begin
            stat_ok_d  = '0;
            stat_err_d = '0;
        end else if (rsp_hsk) begin
            if (!rsp_error_q && (stat_ok_q != 16'hFFFF)) begin
                stat_ok_d = stat_ok_q + 16'd1;
            end else if (rsp_error_q && (stat_err_q != 16'hFFFF)) begin
                stat_err_d = stat_err_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_ok_q  <= '0;
            stat_err_q <= '0;
        end else begin
            stat_ok_q  <= stat_ok_d;
            stat_err_q <= stat_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_ipreg_host_if.sv
// Directed bench for ipreg_host_if with a behavioural IP model; stats checks
// are compiled in when IPREG_HOST_STATS_EN is defined.
module tb_ipreg_host_if;
    import custom_axi_ip_pkg::*;

    localparam int MODE_NOM   = 0;
    localparam int MODE_ERR   = 1;
    localparam int MODE_STUCK = 2;

    typedef struct {
        logic [31:0] cmd;
        int          mode;
        logic [31:0] expData;
        logic        expErr;
        logic        expTo;
        int          expLat;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [31:0] cmd_data_i = '0;
    logic [31:0] ip_data_o;
    logic        ip_enable_o;
    logic [31:0] ip_data_i;
    status_e     ip_status_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_data_o;
    logic        rsp_error_o;
    logic        rsp_timeout_o;
    logic        busy_o;
`ifdef IPREG_HOST_STATS_EN
    logic [15:0] stat_ok_o;
    logic [15:0] stat_err_o;
    logic        stat_clr_i = 1'b0;
`endif

    int          ipMode = MODE_NOM;
    logic        ipRelease = 1'b0;
    logic [31:0] ipOperand;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[5];

    ipreg_host_if #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_data_i    (cmd_data_i),
        .ip_data_o     (ip_data_o),
        .ip_enable_o   (ip_enable_o),
        .ip_data_i     (ip_data_i),
        .ip_status_i   (ip_status_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .rsp_error_o   (rsp_error_o),
        .rsp_timeout_o (rsp_timeout_o),
`ifdef IPREG_HOST_STATS_EN
        .stat_ok_o     (stat_ok_o),
        .stat_err_o    (stat_err_o),
        .stat_clr_i    (stat_clr_i),
`endif
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // IP model: nominal returns operand+1 via BUSY->DONE->IDLE.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ip_status_i <= IDLE;
            ip_data_i   <= '0;
            ipOperand   <= '0;
        end else begin
            case (ip_status_i)
                IDLE: begin
                    if (ip_enable_o) begin
                        ip_status_i <= BUSY;
                        ipOperand   <= ip_data_o;
                    end
                end
                BUSY: begin
                    if (ipMode == MODE_NOM) begin
                        ip_status_i <= DONE;
                        ip_data_i   <= ipOperand + 32'd1;
                    end else if (ipMode == MODE_ERR) begin
                        ip_status_i <= ERROR;
                        ip_data_i   <= 32'hDEAD_BEEF;
                    end else if (ipRelease) begin
                        ip_status_i <= IDLE;
                    end
                end
                default: ip_status_i <= IDLE;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] cmd, output logic accepted);
        @(negedge clk_i);
        cmd_data_i  = cmd;
        cmd_valid_i = 1'b1;
        accepted    = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (cmd_ready_o) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
    endtask

    // Count edges from the accept edge (=1) until rsp_valid_o is seen.
    task automatic waitResponse(output logic got, output int lat, output int enCnt, output logic held);
        got   = 1'b0;
        lat   = 1;
        enCnt = 0;
        held  = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (ip_enable_o) enCnt++;
            if (ip_data_o !== cmd_data_i) held = 1'b0;
            if (rsp_valid_o) begin
                got = 1'b1;
                break;
            end
            @(posedge clk_i);
            lat++;
        end
    endtask

    task automatic runVector(input vec_t v);
        logic acc, got, held;
        int   lat, enCnt;
        ipMode = v.mode;
        applyStimulus(v.cmd, acc);
        checkOutput("cmd_accepted", 32'(acc), 32'd1);
        waitResponse(got, lat, enCnt, held);
        checkOutput("rsp_arrived", 32'(got), 32'd1);
        checkOutput("latency", 32'(lat), 32'(v.expLat));
        checkOutput("enable_pulses", 32'(enCnt), 32'd1);
        checkOutput("ip_data_held", 32'(held), 32'd1);
        checkOutput("rsp_data", rsp_data_o, v.expData);
        checkOutput("rsp_error", 32'(rsp_error_o), 32'(v.expErr));
        if (v.expErr) checkOutput("rsp_timeout", 32'(rsp_timeout_o), 32'(v.expTo));
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1 rsp_ready_i = 1'b0;
        ipRelease = 1'b1;
        @(negedge clk_i);
        checkOutput("rsp_valid_drop", 32'(rsp_valid_o), 32'd0);
        @(posedge clk_i);
        #1 ipRelease = 1'b0;
    endtask

    initial begin
        logic        acc, got, held;
        int          lat, enCnt, unstable, expOk, expErrCnt;
        logic [31:0] snapData;
        logic        snapErr;

        vecs[0] = '{32'h0000_00FF, MODE_NOM,   32'h0000_0100, 1'b0, 1'b0, 5};
        vecs[1] = '{32'h0000_0012, MODE_ERR,   32'hDEAD_BEEF, 1'b1, 1'b0, 4};
        vecs[2] = '{32'h0000_0055, MODE_STUCK, 32'h0000_0000, 1'b1, 1'b1, 10};
        vecs[3] = '{32'h0000_1234, MODE_NOM,   32'h0000_1235, 1'b0, 1'b0, 5};
        vecs[4] = '{32'hFFFF_FFFF, MODE_NOM,   32'h0000_0000, 1'b0, 1'b0, 5};

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("reset_cmd_ready", 32'(cmd_ready_o), 32'd1);
        checkOutput("reset_busy", 32'(busy_o), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("reset_enable", 32'(ip_enable_o), 32'd0);
        checkOutput("reset_ip_data", ip_data_o, 32'd0);
        checkOutput("reset_rsp_data", rsp_data_o, 32'd0);
        checkOutput("reset_rsp_error", 32'({rsp_error_o, rsp_timeout_o}), 32'd0);
        rst_i = 1'b0;

        expOk     = 0;
        expErrCnt = 0;
        for (int i = 0; i < 5; i++) begin
            runVector(vecs[i]);
            if (vecs[i].expErr) expErrCnt++;
            else expOk++;
        end

`ifdef IPREG_HOST_STATS_EN
        @(negedge clk_i);
        checkOutput("stat_ok", 32'(stat_ok_o), 32'(expOk));
        checkOutput("stat_err", 32'(stat_err_o), 32'(expErrCnt));
        stat_clr_i = 1'b1;
        @(posedge clk_i);
        #1 stat_clr_i = 1'b0;
        @(negedge clk_i);
        checkOutput("stat_ok_clr", 32'(stat_ok_o), 32'd0);
        checkOutput("stat_err_clr", 32'(stat_err_o), 32'd0);
`endif

        // Backpressure: response held for 10 cycles with a second command waiting.
        ipMode = MODE_NOM;
        applyStimulus(32'h0000_00A0, acc);
        waitResponse(got, lat, enCnt, held);
        checkOutput("bp_rsp_arrived", 32'(got), 32'd1);
        checkOutput("bp_rsp_data", rsp_data_o, 32'h0000_00A1);
        cmd_data_i  = 32'h0000_00B0;
        cmd_valid_i = 1'b1;
        snapData    = rsp_data_o;
        snapErr     = rsp_error_o;
        unstable    = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            if (rsp_data_o !== snapData || rsp_error_o !== snapErr) unstable++;
            if (rsp_valid_o !== 1'b1 || cmd_ready_o !== 1'b0) unstable++;
        end
        checkOutput("bp_stable", 32'(unstable), 32'd0);
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1 rsp_ready_i = 1'b0;
        @(negedge clk_i);
        checkOutput("bp_not_yet_busy", 32'(busy_o), 32'd0);
        checkOutput("bp_ready_after", 32'(cmd_ready_o), 32'd1);
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("bp_second_issue", 32'(ip_enable_o), 32'd1);
        checkOutput("bp_second_data", ip_data_o, 32'h0000_00B0);
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid_o) begin
                got = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        checkOutput("bp_second_rsp", rsp_data_o, 32'h0000_00B1);
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1 rsp_ready_i = 1'b0;

        // Reset in the middle of WAIT with a stalled IP.
        ipMode = MODE_STUCK;
        applyStimulus(32'h0000_0077, acc);
        repeat (3) @(negedge clk_i);
        checkOutput("mid_wait_busy", 32'(busy_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        checkOutput("rst_ip_data", ip_data_o, 32'd0);
        checkOutput("rst_rsp", 32'({rsp_valid_o, rsp_error_o, rsp_timeout_o}), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i  = 1'b0;
        ipMode = MODE_NOM;
        unstable = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) unstable++;
        end
        checkOutput("rst_no_rsp", 32'(unstable), 32'd0);
        runVector('{32'h0000_0001, MODE_NOM, 32'h0000_0002, 1'b0, 1'b0, 5});

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
